// File: rtl/fp_minmax_tracker_pkg.sv
// Shared constants, state encoding and NaN helper for the fp_minmax_tracker slice.
package fp_minmax_tracker_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int EXP_W      = 8;
  localparam int MAN_W      = 23;

  localparam logic [DATA_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    return (&v[DATA_WIDTH-2 -: EXP_W]) && (|v[MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/fp_comparator.sv
// Combinational float ordering: a_gt_b when a orders strictly above b.
// Sign-magnitude rules: +0 > -0, raw bit patterns otherwise (NaNs included).
module fp_comparator
  import fp_minmax_tracker_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  a_gt_b
);

  logic sign_a;
  logic sign_b;

  assign sign_a = a[DATA_WIDTH-1];
  assign sign_b = b[DATA_WIDTH-1];

  always_comb begin
    a_gt_b = 1'b0;
    if (sign_a != sign_b) begin
      a_gt_b = sign_b;
    end else if (!sign_a) begin
      a_gt_b = a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
    end else begin
      // both negative: smaller magnitude is the larger value
      a_gt_b = a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
    end
  end

endmodule

// File: rtl/fp_minmax_tracker.sv
// Per-frame running max/min (with indices) over a valid/ready float stream, one result beat per frame.
// Optional macro FP_MINMAX_NAN_FILTER_EN: NaN beats are counted but never become an extreme.
module fp_minmax_tracker
  import fp_minmax_tracker_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [IDX_W-1:0]      out_max_idx,
  output logic [IDX_W-1:0]      out_min_idx,
  output logic [IDX_W:0]        out_count,
  output logic                  out_empty
);

  localparam logic [IDX_W:0] LEN_C = (IDX_W+1)'(FRAME_LEN);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [IDX_W-1:0]      max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic [IDX_W:0]        count_q, count_d;
  logic                  gt_max, gt_min;
  logic                  nan_in;

`ifdef FP_MINMAX_NAN_FILTER_EN
  logic have_q, have_d;
  assign nan_in    = is_nan(in_data);
  assign out_empty = (state_q == DONE) && !have_q;
`else
  logic have_q;
  assign nan_in    = 1'b0;
  assign have_q    = 1'b1;
  assign out_empty = 1'b0;
`endif

  fp_comparator u_cmp_max (.a(in_data), .b(max_q),   .a_gt_b(gt_max));
  fp_comparator u_cmp_min (.a(min_q),   .b(in_data), .a_gt_b(gt_min));

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    count_d   = count_q;
`ifdef FP_MINMAX_NAN_FILTER_EN
    have_d    = have_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          max_d     = nan_in ? FP_QNAN : in_data;
          min_d     = nan_in ? FP_QNAN : in_data;
          max_idx_d = '0;
          min_idx_d = '0;
          count_d   = (IDX_W+1)'(1);
`ifdef FP_MINMAX_NAN_FILTER_EN
          have_d    = !nan_in;
`endif
          state_d   = (in_last || LEN_C == (IDX_W+1)'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          count_d = count_q + (IDX_W+1)'(1);
          if (!nan_in && !have_q) begin
            // first real value after leading NaNs seeds both extremes
            max_d     = in_data;
            min_d     = in_data;
            max_idx_d = count_q[IDX_W-1:0];
            min_idx_d = count_q[IDX_W-1:0];
`ifdef FP_MINMAX_NAN_FILTER_EN
            have_d    = 1'b1;
`endif
          end else if (!nan_in) begin
            if (gt_max) begin
              max_d     = in_data;
              max_idx_d = count_q[IDX_W-1:0];
            end
            if (gt_min) begin
              min_d     = in_data;
              min_idx_d = count_q[IDX_W-1:0];
            end
          end
          if (in_last || count_d == LEN_C) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
`ifdef FP_MINMAX_NAN_FILTER_EN
      have_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      count_q   <= count_d;
`ifdef FP_MINMAX_NAN_FILTER_EN
      have_q    <= have_d;
`endif
    end
  end

  assign in_ready    = (state_q != DONE);
  assign out_valid   = (state_q == DONE);
  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
  assign out_count   = count_q;

endmodule

// File: tb/tb_fp_minmax_tracker.sv
// Directed, table-driven bench for fp_minmax_tracker with FRAME_LEN=4.
module tb_fp_minmax_tracker;
  import fp_minmax_tracker_pkg::*;

  localparam int FL = 4;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_max;
  logic [DATA_WIDTH-1:0] out_min;
  logic [IW-1:0]         out_max_idx;
  logic [IW-1:0]         out_min_idx;
  logic [IW:0]           out_count;
  logic                  out_empty;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  fp_minmax_tracker #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min),
    .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
    .out_count(out_count), .out_empty(out_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    n;
    logic [3:0][31:0]      d;
    logic [31:0]           e_max;
    logic [31:0]           e_min;
    int                    e_max_idx;
    int                    e_min_idx;
    int                    e_count;
    logic                  e_empty;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_result(input string nm, input vec_t v);
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " in_ready"},  32'(in_ready), 32'd0);
    chk({nm, " max"},       out_max, v.e_max);
    chk({nm, " min"},       out_min, v.e_min);
    chk({nm, " max_idx"},   32'(out_max_idx), 32'(v.e_max_idx));
    chk({nm, " min_idx"},   32'(out_min_idx), 32'(v.e_min_idx));
    chk({nm, " count"},     32'(out_count), 32'(v.e_count));
    chk({nm, " empty"},     32'(out_empty), 32'(v.e_empty));
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " released out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " released in_ready"},  32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input string nm, input vec_t v);
    int k;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v.d[i];
      in_last  = (i == v.n - 1);
      k = 0;
      while (!in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) chk({nm, " in_ready timeout"}, 32'(in_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result(nm, v);
    release_result(nm);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    vecs[0] = '{4, {32'h0000_0000, 32'h4060_0000, 32'hC000_0000, 32'h3F80_0000},
                32'h4060_0000, 32'hC000_0000, 2, 1, 4, 1'b0};
    vecs[1] = '{2, {32'h0, 32'h0, 32'h3F80_0000, 32'h3F80_0000},
                32'h3F80_0000, 32'h3F80_0000, 0, 0, 2, 1'b0};
    vecs[2] = '{2, {32'h0, 32'h0, 32'h8000_0000, 32'h0000_0000},
                32'h0000_0000, 32'h8000_0000, 0, 1, 2, 1'b0};
    vecs[3] = '{1, {32'h0, 32'h0, 32'h0, 32'h4000_0000},
                32'h4000_0000, 32'h4000_0000, 0, 0, 1, 1'b0};
    vecs[4] = '{4, {32'h4120_0000, 32'hC120_0000, 32'h7F80_0000, 32'hFF80_0000},
                32'h7F80_0000, 32'hFF80_0000, 1, 0, 4, 1'b0};
`ifdef FP_MINMAX_NAN_FILTER_EN
    vecs[5] = '{3, {32'h0, 32'h7FC0_0000, 32'hBF80_0000, 32'h7FC0_0000},
                32'hBF80_0000, 32'hBF80_0000, 1, 1, 3, 1'b0};
    vecs[6] = '{2, {32'h0, 32'h0, 32'h7F80_0001, 32'h7FC0_0000},
                32'h7FC0_0000, 32'h7FC0_0000, 0, 0, 2, 1'b1};
`else
    vecs[5] = '{3, {32'h0, 32'h7FC0_0000, 32'hBF80_0000, 32'h7FC0_0000},
                32'h7FC0_0000, 32'hBF80_0000, 0, 1, 3, 1'b0};
    vecs[6] = '{2, {32'h0, 32'h0, 32'h7F80_0001, 32'h7FC0_0000},
                32'h7FC0_0000, 32'h7F80_0001, 0, 1, 2, 1'b0};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready",  32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset max",       out_max, 32'h0);
    chk("reset min",       out_min, 32'h0);
    chk("reset count",     32'(out_count), 32'd0);
    chk("reset empty",     32'(out_empty), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Overlong frame: done after 4 beats, later beats must wait while result is held
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h3F80_0000 + (i == 0 ? 32'h0 : 32'h0080_0000 + 32'(i - 1) * 32'h0040_0000);
      in_last  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_data = 32'h40A0_0000;
    v = '{4, '0, 32'h4080_0000, 32'h3F80_0000, 3, 0, 4, 1'b0};
    check_result("long", v);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("long hold max",      out_max, 32'h4080_0000);
      chk("long hold in_ready", 32'(in_ready), 32'd0);
      chk("long hold count",    32'(out_count), 32'd4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("long idle in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h40C0_0000;
    in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    v = '{2, '0, 32'h40C0_0000, 32'h40A0_0000, 1, 0, 2, 1'b0};
    check_result("long tail", v);
    release_result("long tail");

    // Reset mid-frame discards the partial result
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h4110_0000;
      in_last  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst count",     32'(out_count), 32'd0);
    chk("midrst max",       out_max, 32'h0);
    chk("midrst in_ready",  32'(in_ready), 32'd1);
    rst_n = 1'b1;
    run_frame("after reset", vecs[3]);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
